pll_reset_sequencer: RTL

- Controls the clock-generation PLL (126/42 MHz outputs from the 50 MHz reference). Asserts the PLL reset at power-up and on request, waits for lock with a timeout and retries, qualifies lock stability, then releases the downstream system reset.
- On loss of lock it re-asserts the system reset and resequences the PLL.
- Clocked only by the free-running reference clock, so it works while the PLL outputs are invalid.

---
 rtl/pll_ctrl_pkg.sv | 19 +
 rtl/sync_2ff.sv | 26 ++
 rtl/pll_reset_sequencer.sv | 116 +++++++++++
 3 files changed

// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg: state encoding and counter sizing shared by the PLL reset sequencer.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_HOLD = 3'd0,
        ST_WAIT = 3'd1,
        ST_STAB = 3'd2,
        ST_RUN  = 3'd3,
        ST_FAIL = 3'd4
    } pll_state_e;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous status inputs, async active-low reset to 0.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: sequences PLL reset, lock wait/retry and lock qualification on refclk, then releases sys_rst_n.
// When pll_locked rises as pll_rst falls, ready rises on refclk edge RST_CYCLES+2+1+STABLE_CYCLES after rst_n release.
module pll_reset_sequencer
    import pll_ctrl_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 500000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int LOL_W         = 8
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             restart_req,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             ready,
    output logic             fail,
    output logic [2:0]       state,
    output logic [LOL_W-1:0] lol_count
);

    localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int RW = cnt_width(MAX_RETRIES, 0, 0);
    localparam logic [CW-1:0] RST_END   = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TMO_END   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_END   = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    logic             lk_s;
    pll_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic [LOL_W-1:0] lol_q, lol_d;
    logic             pll_rst_q, sys_rst_n_q, ready_q, fail_q;

    sync_2ff #(.W(1)) u_lock_sync (
        .clk  (refclk),
        .rst_n(rst_n),
        .d_i  (pll_locked),
        .q_o  (lk_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        retry_d = retry_q;
        lol_d   = lol_q;
        if (restart_req) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_HOLD: state_d = (cnt_q == RST_END) ? ST_WAIT : ST_HOLD;
                ST_WAIT: begin
                    if (lk_s) begin
                        state_d = ST_STAB;
                    end else if (cnt_q == TMO_END) begin
                        state_d = (retry_q < RETRY_MAX) ? ST_HOLD : ST_FAIL;
                        retry_d = (retry_q < RETRY_MAX) ? retry_q + 1'b1 : retry_q;
                    end
                end
                ST_STAB: begin
                    if (!lk_s) begin
                        state_d = ST_WAIT;
                    end else if (cnt_q == STB_END) begin
                        state_d = ST_RUN;
                        retry_d = '0;
                    end
                end
                ST_RUN: begin
                    if (!lk_s) begin
                        state_d = ST_HOLD;
                        lol_d   = (&lol_q) ? lol_q : lol_q + 1'b1;
                    end
                end
                ST_FAIL: state_d = ST_FAIL;
                default: state_d = ST_HOLD;
            endcase
        end
        // one shared counter: restarts on every state change and idles in RUN/FAIL
        if (state_d != state_q || state_q == ST_RUN || state_q == ST_FAIL) cnt_d = '0;
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HOLD;
            cnt_q       <= '0;
            retry_q     <= '0;
            lol_q       <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            lol_q       <= lol_d;
            pll_rst_q   <= (state_d == ST_HOLD) || (state_d == ST_FAIL);
            sys_rst_n_q <= (state_d == ST_RUN);
            ready_q     <= (state_d == ST_RUN);
            fail_q      <= (state_d == ST_FAIL);
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign state     = state_q;
    assign lol_count = lol_q;

endmodule
